// File: rtl/bit_serializer.sv
// Parallel-to-serial front end with a one-word pending buffer, feeding the sequence detector's x input.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             byte_done,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             byte_done_q, byte_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             cur_bit;
  logic [WIDTH-1:0] sreg_shifted;
  logic             last_bit;
  logic             word_end;
  logic             load;

  assign cur_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign last_bit     = (bcnt_q == BW'(WIDTH - 1));

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    sreg_d        = sreg_q;
    bcnt_d        = bcnt_q;
    gcnt_d        = gcnt_q;
    x_d           = 1'b0;
    x_valid_d     = 1'b0;
    frame_start_d = 1'b0;
    byte_done_d   = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_d         = par_q;
`endif
    word_end      = 1'b0;
    load          = 1'b0;

    // Accept and drain are exclusive: accept needs pend empty, drain needs it full.
    if (din_valid && !pend_full_q) begin
      pend_d      = din;
      pend_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pend_full_q) load = 1'b1;
      end
      SHIFT: begin
        x_d           = cur_bit;
        x_valid_d     = 1'b1;
        frame_start_d = (bcnt_q == '0);
        sreg_d        = sreg_shifted;
        bcnt_d        = bcnt_q + BW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d         = par_q ^ cur_bit;
        if (last_bit) state_d = PAR;
`else
        if (last_bit) begin
          byte_done_d = 1'b1;
          word_end    = 1'b1;
        end
`endif
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PAR: begin
        x_d         = par_q;
        x_valid_d   = 1'b1;
        byte_done_d = 1'b1;
        word_end    = 1'b1;
      end
`endif
      GAP: begin
        gcnt_d = gcnt_q + 4'd1;
        if (gcnt_q == 4'(GAP_CYCLES - 1)) begin
          if (pend_full_q) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reloading straight from the last bit keeps back-to-back words gapless.
    if (word_end) begin
      if (GAP_CYCLES > 0) begin
        state_d = GAP;
        gcnt_d  = 4'd0;
      end else if (pend_full_q) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    if (load) begin
      sreg_d      = pend_q;
      pend_full_d = 1'b0;
      bcnt_d      = '0;
      state_d     = SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      sreg_q        <= '0;
      bcnt_q        <= '0;
      gcnt_q        <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
      byte_done_q   <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      sreg_q        <= sreg_d;
      bcnt_q        <= bcnt_d;
      gcnt_q        <= gcnt_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
      byte_done_q   <= byte_done_d;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign din_ready   = ~pend_full_q;
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;
  assign byte_done   = byte_done_q;
  assign busy        = (state_q != IDLE) || pend_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: instance 0 is MSB-first gapless, instance 1 is LSB-first with 3 gap cycles.
module tb_bit_serializer;

  typedef struct {
    logic x;
    logic fs;
    logic bd;
    bit   tight;
    bit   cold;
    int   acc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] din        [2];
  logic       din_valid  [2];
  logic       din_ready  [2];
  logic       x_s        [2];
  logic       x_valid    [2];
  logic       frame_start[2];
  logic       byte_done  [2];
  logic       busy       [2];

  exp_t q0[$];
  exp_t q1[$];
  int   errors;
  int   checks;
  int   cyc;
  int   idle_cnt[2];
  int   nbits[2];

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
    .x(x_s[0]), .x_valid(x_valid[0]), .frame_start(frame_start[0]), .byte_done(byte_done[0]),
    .busy(busy[0]));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
    .x(x_s[1]), .x_valid(x_valid[1]), .frame_start(frame_start[1]), .byte_done(byte_done[1]),
    .busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int gapOf(input int g);
    return (g == 0) ? 0 : 3;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Reference stream for one word: payload in wire order, then optional even parity.
  task automatic pushWord(input int g, input logic [7:0] w, input bit tight, input bit cold, input int acc);
    exp_t e;
    int   n;
`ifdef BIT_SERIALIZER_PARITY_EN
    n = 9;
`else
    n = 8;
`endif
    for (int i = 0; i < 8; i++) begin
      e.x     = (g == 0) ? w[7 - i] : w[i];
      e.fs    = (i == 0);
      e.bd    = (i == n - 1);
      e.tight = tight && (i == 0);
      e.cold  = cold && (i == 0);
      e.acc   = acc;
      if (g == 0) q0.push_back(e); else q1.push_back(e);
    end
`ifdef BIT_SERIALIZER_PARITY_EN
    e.x = ^w; e.fs = 1'b0; e.bd = 1'b1; e.tight = 1'b0; e.cold = 1'b0; e.acc = acc;
    if (g == 0) q0.push_back(e); else q1.push_back(e);
`endif
  endtask

  task automatic monitorLoop();
    exp_t e;
    int   r;
    bit   empty;
    forever begin
      @(posedge clk or negedge clk);
      if (clk) begin
        for (int g = 0; g < 2; g++) begin
          r = (g == 0) ? q0.size() : q1.size();
          if (!rst) begin
            if (g == 0) q0.delete(); else q1.delete();
            idle_cnt[g] = 0;
          end else if (din_valid[g] && din_ready[g]) begin
            pushWord(g, din[g], r >= 2, (r == 0) && !busy[g], cyc);
          end
        end
        cyc++;
      end else begin
        for (int g = 0; g < 2; g++) begin
          if (x_valid[g]) begin
            empty = (g == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              checkOutput($sformatf("cfg%0d_unexpected_bit", g), 1, 0);
            end else begin
              e = (g == 0) ? q0.pop_front() : q1.pop_front();
              checkOutput($sformatf("cfg%0d_x", g), int'(x_s[g]), int'(e.x));
              checkOutput($sformatf("cfg%0d_frame_start", g), int'(frame_start[g]), int'(e.fs));
              checkOutput($sformatf("cfg%0d_byte_done", g), int'(byte_done[g]), int'(e.bd));
              if (e.tight) checkOutput($sformatf("cfg%0d_gap_len", g), idle_cnt[g], gapOf(g));
              if (e.cold)  checkOutput($sformatf("cfg%0d_latency", g), cyc, e.acc + 3);
            end
            idle_cnt[g] = 0;
            nbits[g]++;
          end else begin
            checkOutput($sformatf("cfg%0d_idle_x", g), int'(x_s[g]), 0);
            checkOutput($sformatf("cfg%0d_idle_flags", g), int'({frame_start[g], byte_done[g]}), 0);
            idle_cnt[g]++;
          end
        end
      end
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer, valid still high.
  task automatic applyStimulus(input int g, input logic [7:0] w);
    int t;
    t = 0;
    din[g]       = w;
    din_valid[g] = 1'b1;
    while (!din_ready[g] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) checkOutput($sformatf("cfg%0d_ready_timeout", g), 0, 1);
    @(negedge clk);
    checkOutput($sformatf("cfg%0d_ready_low_when_full", g), int'(din_ready[g]), 0);
  endtask

  task automatic idleInput(input int g, input int n);
    din_valid[g] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy[0] || busy[1]) && t < 600) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_timeout", int'(t >= 600), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    rst    = 1'b0;
    for (int g = 0; g < 2; g++) begin
      din[g] = 8'h00; din_valid[g] = 1'b0; idle_cnt[g] = 0; nbits[g] = 0;
    end
    fork
      monitorLoop();
    join_none

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("cfg%0d_rst_x", g), int'(x_s[g]), 0);
      checkOutput($sformatf("cfg%0d_rst_x_valid", g), int'(x_valid[g]), 0);
      checkOutput($sformatf("cfg%0d_rst_busy", g), int'(busy[g]), 0);
      checkOutput($sformatf("cfg%0d_rst_din_ready", g), int'(din_ready[g]), 1);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("cfg%0d_post_rst_x_valid", g), int'(x_valid[g]), 0);
      checkOutput($sformatf("cfg%0d_post_rst_busy", g), int'(busy[g]), 0);
    end

    $display("[TB] single word 0xB4 on both orders");
    applyStimulus(0, 8'hB4); idleInput(0, 1);
    applyStimulus(1, 8'hB4); idleInput(1, 1);
    waitDrain();

    $display("[TB] back-to-back 0xF0, 0x0F");
    applyStimulus(0, 8'hF0); applyStimulus(0, 8'h0F); idleInput(0, 1);
    applyStimulus(1, 8'hF0); applyStimulus(1, 8'h0F); idleInput(1, 1);
    waitDrain();

    $display("[TB] randomized words");
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 30; i++) begin
        applyStimulus(g, 8'($urandom));
        if ($urandom_range(0, 1) == 1) idleInput(g, $urandom_range(1, 12));
      end
      idleInput(g, 1);
    end
    waitDrain();

    $display("[TB] reset mid-word");
    begin
      int base;
      int t;
      base = nbits[0];
      t = 0;
      applyStimulus(0, 8'hFF);
      din_valid[0] = 1'b0;
      while (nbits[0] < base + 4 && t < 100) begin
        @(negedge clk); #1;
        t++;
      end
      checkOutput("mid_rst_bits_timeout", int'(t >= 100), 0);
      rst = 1'b0;
      @(negedge clk); #1;
      checkOutput("mid_rst_x_valid", int'(x_valid[0]), 0);
      checkOutput("mid_rst_byte_done", int'(byte_done[0]), 0);
      checkOutput("mid_rst_din_ready", int'(din_ready[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(0, 8'h81); idleInput(0, 1);
      waitDrain();
    end

    checkOutput("final_q0_empty", q0.size(), 0);
    checkOutput("final_q1_empty", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
